// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator: key codes, ALU operations, FSM states
// and the key decoding helpers.
package calc_pkg;

    typedef enum logic [4:0] {
        KEY_0     = 5'd0,
        KEY_1     = 5'd1,
        KEY_2     = 5'd2,
        KEY_3     = 5'd3,
        KEY_4     = 5'd4,
        KEY_5     = 5'd5,
        KEY_6     = 5'd6,
        KEY_7     = 5'd7,
        KEY_8     = 5'd8,
        KEY_9     = 5'd9,
        KEY_ENTER = 5'd10,
        KEY_CLEAR = 5'd11,
        KEY_DROP  = 5'd12,
        KEY_SWAP  = 5'd13,
        KEY_ADD   = 5'd14,
        KEY_SUB   = 5'd15,
        KEY_MUL   = 5'd16
    } key_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Digit key codes coincide with their numeric value.
    function automatic logic is_digit(input key_t key);
        return (key <= KEY_9);
    endfunction

    function automatic logic is_op(input key_t key);
        return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
    endfunction

    function automatic op_t key_to_op(input key_t key);
        op_t op;
        case (key)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/operand_stack.sv
// Operand stack kept as a shift register: slot 0 is always the top, slot 1
// the next entry, so peeks need no variable indexing.
module operand_stack #(
    parameter int Width      = 32,
    parameter int StackDepth = 4,
    localparam int DepthW    = $clog2(StackDepth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [Width-1:0]  push_data_i,
    input  logic              pop_i,
    input  logic              pop2_i,
    input  logic              swap_i,
    output logic [Width-1:0]  top_o,
    output logic [Width-1:0]  next_o,
    output logic [DepthW-1:0] depth_o
);

    logic [Width-1:0]  mem_q [StackDepth];
    logic [Width-1:0]  mem_d [StackDepth];
    logic [DepthW-1:0] depth_q;
    logic [DepthW-1:0] depth_d;
    logic              full_s;

    assign full_s  = (depth_q == DepthW'(StackDepth));
    assign top_o   = mem_q[0];
    assign next_o  = mem_q[1];
    assign depth_o = depth_q;

    // Next stack contents; vacated slots are zeroed so empty peeks read 0.
    always_comb begin
        for (int i = 0; i < StackDepth; i++) begin
            mem_d[i] = mem_q[i];
        end
        depth_d = depth_q;
        if (clear_i) begin
            for (int i = 0; i < StackDepth; i++) begin
                mem_d[i] = '0;
            end
            depth_d = '0;
        end else if (push_i && !full_s) begin
            mem_d[0] = push_data_i;
            for (int i = 1; i < StackDepth; i++) begin
                mem_d[i] = mem_q[i-1];
            end
            depth_d = depth_q + DepthW'(1);
        end else if (pop2_i && (depth_q >= DepthW'(2))) begin
            for (int i = 0; i < StackDepth - 2; i++) begin
                mem_d[i] = mem_q[i+2];
            end
            mem_d[StackDepth-2] = '0;
            mem_d[StackDepth-1] = '0;
            depth_d = depth_q - DepthW'(2);
        end else if (pop_i && (depth_q != DepthW'(0))) begin
            for (int i = 0; i < StackDepth - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[StackDepth-1] = '0;
            depth_d = depth_q - DepthW'(1);
        end else if (swap_i && (depth_q >= DepthW'(2))) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[0];
        end else begin
            depth_d = depth_q;
        end
    end

    // Stack storage and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < StackDepth; i++) begin
                mem_q[i] <= '0;
            end
            depth_q <= '0;
        end else begin
            for (int i = 0; i < StackDepth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/rpn_calculator.sv
// RPN calculator front end: key entry, operand stack management and an
// external ALU driven through valid/ready request and response handshakes.
module rpn_calculator
    import calc_pkg::*;
#(
    parameter int Width      = 32,
    parameter int NumDigits  = 8,
    parameter int StackDepth = 4,
    localparam int DepthW    = $clog2(StackDepth + 1),
    localparam int CntW      = $clog2(NumDigits + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_valid_i,
    input  key_t              key_i,
    output logic              key_ready_o,
    output logic [Width-1:0]  display_o,
    output logic [DepthW-1:0] depth_o,
    output logic              error_o,
    output logic              busy_o,
    output logic [Width-1:0]  alu_left_o,
    output logic [Width-1:0]  alu_right_o,
    output op_t               alu_op_o,
    output logic              alu_in_valid_o,
    input  logic              alu_in_ready_i,
    input  logic [Width-1:0]  alu_result_i,
    input  logic              alu_out_valid_i,
    output logic              alu_out_ready_o
);

    state_t            state_q, state_d;
    logic [Width-1:0]  entry_q, entry_d;
    logic              active_q, active_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [Width-1:0]  left_q, left_d;
    logic [Width-1:0]  right_q, right_d;
    op_t               op_q, op_d;

    logic              stk_clear_s;
    logic              stk_push_s;
    logic [Width-1:0]  stk_data_s;
    logic              stk_pop_s;
    logic              stk_pop2_s;
    logic              stk_swap_s;
    logic [Width-1:0]  stk_top_s;
    logic [Width-1:0]  stk_next_s;
    logic [DepthW-1:0] stk_depth_s;
    logic              stk_empty_s;
    logic              stk_full_s;

    operand_stack #(
        .Width      (Width),
        .StackDepth (StackDepth)
    ) u_stack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (stk_clear_s),
        .push_i      (stk_push_s),
        .push_data_i (stk_data_s),
        .pop_i       (stk_pop_s),
        .pop2_i      (stk_pop2_s),
        .swap_i      (stk_swap_s),
        .top_o       (stk_top_s),
        .next_o      (stk_next_s),
        .depth_o     (stk_depth_s)
    );

    assign stk_empty_s = (stk_depth_s == DepthW'(0));
    assign stk_full_s  = (stk_depth_s == DepthW'(StackDepth));

    // Key interpretation, ALU sequencing and stack command generation.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        active_d    = active_q;
        count_d     = count_q;
        left_d      = left_q;
        right_d     = right_q;
        op_d        = op_q;
        stk_clear_s = 1'b0;
        stk_push_s  = 1'b0;
        stk_data_s  = '0;
        stk_pop_s   = 1'b0;
        stk_pop2_s  = 1'b0;
        stk_swap_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!key_valid_i) begin
                    state_d = ST_IDLE;
                end else if (is_digit(key_i)) begin
                    if (count_q != CntW'(NumDigits)) begin
                        entry_d  = (entry_q * Width'(10)) + Width'(key_i);
                        active_d = 1'b1;
                        count_d  = count_q + CntW'(1);
                    end else begin
                        entry_d = entry_q;
                    end
                end else if (is_op(key_i)) begin
                    // With a live entry the entry is the right operand.
                    if (active_q && !stk_empty_s) begin
                        left_d    = stk_top_s;
                        right_d   = entry_q;
                        op_d      = key_to_op(key_i);
                        stk_pop_s = 1'b1;
                        entry_d   = '0;
                        active_d  = 1'b0;
                        count_d   = '0;
                        state_d   = ST_ISSUE;
                    end else if (!active_q && (stk_depth_s >= DepthW'(2))) begin
                        left_d     = stk_next_s;
                        right_d    = stk_top_s;
                        op_d       = key_to_op(key_i);
                        stk_pop2_s = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    case (key_i)
                        KEY_ENTER: begin
                            if (active_q) begin
                                if (stk_full_s) begin
                                    state_d = ST_ERROR;
                                end else begin
                                    stk_push_s = 1'b1;
                                    stk_data_s = entry_q;
                                    entry_d    = '0;
                                    active_d   = 1'b0;
                                    count_d    = '0;
                                end
                            end else if (stk_empty_s || stk_full_s) begin
                                state_d = ST_ERROR;
                            end else begin
                                stk_push_s = 1'b1;
                                stk_data_s = stk_top_s;
                            end
                        end
                        KEY_CLEAR: begin
                            stk_clear_s = 1'b1;
                            entry_d     = '0;
                            active_d    = 1'b0;
                            count_d     = '0;
                        end
                        KEY_DROP: begin
                            if (stk_empty_s) begin
                                state_d = ST_ERROR;
                            end else begin
                                stk_pop_s = 1'b1;
                            end
                        end
                        KEY_SWAP: begin
                            if (stk_depth_s < DepthW'(2)) begin
                                state_d = ST_ERROR;
                            end else begin
                                stk_swap_s = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (alu_in_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (alu_out_valid_i) begin
                    stk_push_s = 1'b1;
                    stk_data_s = alu_result_i;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERROR: begin
                if (key_valid_i && (key_i == KEY_CLEAR)) begin
                    stk_clear_s = 1'b1;
                    entry_d     = '0;
                    active_d    = 1'b0;
                    count_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, entry accumulator and latched ALU request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            entry_q  <= '0;
            active_q <= 1'b0;
            count_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            op_q     <= OP_ADD;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            active_q <= active_d;
            count_q  <= count_d;
            left_q   <= left_d;
            right_q  <= right_d;
            op_q     <= op_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        key_ready_o     = (state_q == ST_IDLE) || (state_q == ST_ERROR);
        busy_o          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        error_o         = (state_q == ST_ERROR);
        alu_in_valid_o  = (state_q == ST_ISSUE);
        alu_out_ready_o = (state_q == ST_WAIT);
        alu_left_o      = left_q;
        alu_right_o     = right_q;
        alu_op_o        = op_q;
        depth_o         = stk_depth_s;
        if (state_q == ST_ERROR) begin
            display_o = '0;
        end else if (active_q) begin
            display_o = entry_q;
        end else if (!stk_empty_s) begin
            display_o = stk_top_s;
        end else begin
            display_o = '0;
        end
    end

endmodule

// File: tb/tb_rpn_calculator.sv
// Directed bench for rpn_calculator with hand-computed expectations and an
// ALU played by hand from the stimulus sequence.
module tb_rpn_calculator;
    import calc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    key_t        key;
    logic        key_ready;
    logic [31:0] display;
    logic [2:0]  depth;
    logic        error;
    logic        busy;
    logic [31:0] alu_left;
    logic [31:0] alu_right;
    op_t         alu_op;
    logic        alu_in_valid;
    logic        alu_in_ready;
    logic [31:0] alu_result;
    logic        alu_out_valid;
    logic        alu_out_ready;

    int total;
    int bad;

    rpn_calculator dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .key_valid_i     (key_valid),
        .key_i           (key),
        .key_ready_o     (key_ready),
        .display_o       (display),
        .depth_o         (depth),
        .error_o         (error),
        .busy_o          (busy),
        .alu_left_o      (alu_left),
        .alu_right_o     (alu_right),
        .alu_op_o        (alu_op),
        .alu_in_valid_o  (alu_in_valid),
        .alu_in_ready_i  (alu_in_ready),
        .alu_result_i    (alu_result),
        .alu_out_valid_i (alu_out_valid),
        .alu_out_ready_o (alu_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input key_t k);
        @(negedge clk);
        key_valid = 1'b1;
        key       = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // One-cycle request acceptance, then a one-cycle response with res.
    task automatic serve(input logic [31:0] res);
        @(negedge clk);
        alu_in_ready = 1'b1;
        @(negedge clk);
        alu_in_ready = 1'b0;
        chk("wait_out_ready", 32'(alu_out_ready), 32'd1);
        chk("wait_in_valid", 32'(alu_in_valid), 32'd0);
        alu_result    = res;
        alu_out_valid = 1'b1;
        @(negedge clk);
        alu_out_valid = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        key_valid     = 1'b0;
        key           = KEY_0;
        alu_in_ready  = 1'b0;
        alu_result    = 32'd0;
        alu_out_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_key_ready", 32'(key_ready), 32'd1);
        chk("rst_display", display, 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_valid", 32'(alu_in_valid), 32'd0);
        chk("rst_out_ready", 32'(alu_out_ready), 32'd0);
        rst_n = 1'b1;

        // 12 Enter 34 Add
        press(KEY_1);
        press(KEY_2);
        chk("entry_12", display, 32'd12);
        press(KEY_ENTER);
        chk("push_depth", 32'(depth), 32'd1);
        chk("push_display", display, 32'd12);
        press(KEY_3);
        press(KEY_4);
        chk("entry_34", display, 32'd34);
        press(KEY_ADD);
        chk("issue_valid", 32'(alu_in_valid), 32'd1);
        chk("issue_left", alu_left, 32'd12);
        chk("issue_right", alu_right, 32'd34);
        chk("issue_op", 32'(alu_op), 32'(OP_ADD));

        // ALU stalls for five cycles while keys are offered
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_key_ready", 32'(key_ready), 32'd0);
            chk("stall_left", alu_left, 32'd12);
            chk("stall_right", alu_right, 32'd34);
            chk("stall_valid", 32'(alu_in_valid), 32'd1);
            key_valid = (i % 2 == 0);
            key       = KEY_9;
            @(negedge clk);
        end
        key_valid = 1'b0;
        serve(32'd46);
        chk("add_display", display, 32'd46);
        chk("add_depth", 32'(depth), 32'd1);
        chk("add_busy", 32'(busy), 32'd0);
        chk("add_key_ready", 32'(key_ready), 32'd1);

        press(KEY_CLEAR);
        chk("clear_depth", 32'(depth), 32'd0);
        chk("clear_display", display, 32'd0);

        // Overflow: four pushes fill the stack, the fifth errors
        for (int i = 0; i < 4; i++) begin
            press(KEY_7);
            press(KEY_ENTER);
        end
        chk("full_depth", 32'(depth), 32'd4);
        chk("full_display", display, 32'd7);
        press(KEY_7);
        press(KEY_ENTER);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_display", display, 32'd0);
        chk("ovf_depth", 32'(depth), 32'd4);
        chk("err_key_ready", 32'(key_ready), 32'd1);
        press(KEY_DROP);
        chk("err_discard_depth", 32'(depth), 32'd4);
        chk("err_sticky", 32'(error), 32'd1);
        press(KEY_CLEAR);
        chk("ovf_clr_depth", 32'(depth), 32'd0);
        chk("ovf_clr_error", 32'(error), 32'd0);

        // Digit limit then operator underflow
        for (int i = 0; i < 9; i++) begin
            press(KEY_9);
        end
        chk("digit_limit", display, 32'd99999999);
        press(KEY_ADD);
        chk("unf_error", 32'(error), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);
        press(KEY_CLEAR);

        press(KEY_ENTER);
        chk("dup_empty_error", 32'(error), 32'd1);
        press(KEY_CLEAR);
        chk("dup_clr_error", 32'(error), 32'd0);

        // 5 Enter 3 Enter Swap Sub
        press(KEY_5);
        press(KEY_ENTER);
        press(KEY_3);
        press(KEY_ENTER);
        chk("pre_swap_top", display, 32'd3);
        press(KEY_SWAP);
        chk("swap_top", display, 32'd5);
        chk("swap_depth", 32'(depth), 32'd2);
        press(KEY_SUB);
        chk("sub_left", alu_left, 32'd3);
        chk("sub_right", alu_right, 32'd5);
        chk("sub_op", 32'(alu_op), 32'(OP_SUB));
        chk("sub_depth", 32'(depth), 32'd0);
        serve(32'hFFFF_FFFE);
        chk("sub_display", display, 32'hFFFF_FFFE);
        chk("sub_res_depth", 32'(depth), 32'd1);

        press(KEY_ENTER);
        chk("dup_depth", 32'(depth), 32'd2);
        chk("dup_display", display, 32'hFFFF_FFFE);
        press(KEY_DROP);
        chk("drop_depth", 32'(depth), 32'd1);
        press(KEY_DROP);
        press(KEY_DROP);
        chk("drop_empty_error", 32'(error), 32'd1);
        press(KEY_CLEAR);

        // Reset during WAIT aborts the operation
        press(KEY_2);
        press(KEY_ENTER);
        press(KEY_3);
        press(KEY_MUL);
        chk("mul_op", 32'(alu_op), 32'(OP_MUL));
        @(negedge clk);
        alu_in_ready = 1'b1;
        @(negedge clk);
        alu_in_ready = 1'b0;
        chk("mul_wait", 32'(alu_out_ready), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_key_ready", 32'(key_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        alu_result    = 32'd6;
        alu_out_valid = 1'b1;
        @(negedge clk);
        alu_out_valid = 1'b0;
        @(negedge clk);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_display", display, 32'd0);
        chk("abort_out_ready", 32'(alu_out_ready), 32'd0);
        chk("abort_idle", 32'(key_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
